fetch_stage: RTL and testbench

- Instruction-fetch stage with PC register and IF/ID pipeline latch for the 5-stage CPU.
- Drives the instruction-memory read request and holds the IF/ID latch.
- Consumes pc_en, stall_ifid and flush_ifid from the hazard unit, plus branch/jump redirects resolved downstream.
- Feeds the decode stage.

---
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, I-mem read request and the IF/ID latch.
// Redirects (jump > branch) and sequential PC+4 advance happen only while
// fetching with pc_en high; halt freezes the stage until reset.
module fetch_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pc_en,
  input  logic        stall_ifid,
  input  logic        flush_ifid,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_ifid,
  output logic [31:0] pcplus4_ifid,
  output logic        valid_ifid,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  state_t      state;
  logic [31:0] pc;
  ifid_t       ifid;
  logic        ren_q;
  logic        halted_q;

  logic        in_fetch;
  logic        redirect;
  logic        halt_now;
  logic [31:0] pc_plus4;

  assign in_fetch = (state == FETCH);
  assign redirect = jump | take_branch;
  assign halt_now = in_fetch & halt;
  assign pc_plus4 = pc + 32'd4;  // wraps mod 2^32

  // Control FSM with registered read-enable and halted flags
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      ren_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          ren_q <= 1'b1;
        end
        FETCH: begin
          if (halt) begin
            state    <= HALTED;
            ren_q    <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        HALTED: begin
          state    <= HALTED;
          ren_q    <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ren_q <= 1'b0;
        end
      endcase
    end
  end

  // PC update: jump beats branch beats sequential advance; halt freezes PC
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= PC_INIT;
    end else if (in_fetch && !halt && pc_en) begin
      if (jump)             pc <= {jump_target[31:2], 2'b00};
      else if (take_branch) pc <= {branch_target[31:2], 2'b00};
      else if (ihit)        pc <= pc_plus4;
    end
  end

  // IF/ID latch: flush (or halt) > stall > fresh fetch > bubble
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ifid <= '{instr: NOP_WORD, pcplus4: 32'h0, valid: 1'b0};
    end else if (flush_ifid || halt_now) begin
      ifid <= '{instr: NOP_WORD, pcplus4: 32'h0, valid: 1'b0};
    end else if (stall_ifid) begin
      ifid <= ifid;
    end else if (in_fetch && ihit && pc_en && !redirect) begin
      ifid <= '{instr: imemload, pcplus4: pc_plus4, valid: 1'b1};
    end else begin
      ifid <= '{instr: NOP_WORD, pcplus4: 32'h0, valid: 1'b0};
    end
  end

  assign imemREN      = ren_q;
  assign imemaddr     = pc;
  assign instr_ifid   = ifid.instr;
  assign pcplus4_ifid = ifid.pcplus4;
  assign valid_ifid   = ifid.valid;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, miss, stall/flush,
// redirect priority, wrap-around, halt and reset.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en, stall_ifid, flush_ifid, take_branch, jump, halt, ihit;
  logic [31:0] branch_target, jump_target, imemload;
  logic        imemREN, valid_ifid, halted;
  logic [31:0] imemaddr, instr_ifid, pcplus4_ifid;

  int total = 0;
  int fails = 0;

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .stall_ifid(stall_ifid),
    .flush_ifid(flush_ifid), .take_branch(take_branch),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .halt(halt), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
    .imemaddr(imemaddr), .instr_ifid(instr_ifid), .pcplus4_ifid(pcplus4_ifid),
    .valid_ifid(valid_ifid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle away from it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] i, input logic [31:0] p4, input logic v);
    chk({tag, ".instr"}, instr_ifid, i);
    chk({tag, ".pc4"}, pcplus4_ifid, p4);
    chk({tag, ".valid"}, {31'd0, valid_ifid}, {31'd0, v});
  endtask

  initial begin
    nRST = 1'b0; pc_en = 1'b0; stall_ifid = 1'b0; flush_ifid = 1'b0;
    take_branch = 1'b0; jump = 1'b0; halt = 1'b0; ihit = 1'b0;
    branch_target = '0; jump_target = '0; imemload = '0;

    // reset state
    step(); step();
    chk("rst.ren", {31'd0, imemREN}, 32'd0);
    chk("rst.addr", imemaddr, 32'h0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);

    // release; one IDLE cycle then FETCH
    nRST = 1'b1; pc_en = 1'b1; ihit = 1'b1; imemload = 32'hA000_0000;
    #1;
    chk("idle.ren", {31'd0, imemREN}, 32'd0);
    step();
    chk("f0.ren", {31'd0, imemREN}, 32'd1);
    chk("f0.addr", imemaddr, 32'h0);
    chk_ifid("f0", 32'h0, 32'h0, 1'b0);
    step();
    chk("f1.addr", imemaddr, 32'h4);
    chk_ifid("f1", 32'hA000_0000, 32'h4, 1'b1);
    imemload = 32'hA000_0004;
    step();
    chk("f2.addr", imemaddr, 32'h8);
    chk_ifid("f2", 32'hA000_0004, 32'h8, 1'b1);

    // miss: three cycles without ihit at PC=8
    ihit = 1'b0; imemload = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("miss.addr", imemaddr, 32'h8);
      chk_ifid("miss", 32'h0, 32'h0, 1'b0);
    end
    ihit = 1'b1; imemload = 32'hA000_0008;
    step();
    chk("hit.addr", imemaddr, 32'hC);
    chk_ifid("hit", 32'hA000_0008, 32'hC, 1'b1);

    // stall with pc_en low: everything frozen
    stall_ifid = 1'b1; pc_en = 1'b0; imemload = 32'h5555_5555;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall.addr", imemaddr, 32'hC);
      chk_ifid("stall", 32'hA000_0008, 32'hC, 1'b1);
    end
    flush_ifid = 1'b1;
    step();
    chk("flush.addr", imemaddr, 32'hC);
    chk_ifid("flush", 32'h0, 32'h0, 1'b0);

    // redirect to 0x20 (low bits dropped), no ihit
    stall_ifid = 1'b0; flush_ifid = 1'b0; pc_en = 1'b1; ihit = 1'b0;
    jump = 1'b1; jump_target = 32'h22;
    step();
    chk("j20.addr", imemaddr, 32'h20);
    // jump beats branch, fetched word dropped
    jump_target = 32'h40; take_branch = 1'b1; branch_target = 32'h103;
    ihit = 1'b1; imemload = 32'h7777_7777;
    step();
    chk("jb.addr", imemaddr, 32'h40);
    chk_ifid("jb", 32'h0, 32'h0, 1'b0);
    jump = 1'b0;
    step();
    chk("br.addr", imemaddr, 32'h100);
    chk_ifid("br", 32'h0, 32'h0, 1'b0);

    // wrap-around from 0xFFFFFFFC
    take_branch = 1'b0; jump = 1'b1; jump_target = 32'hFFFF_FFFC; ihit = 1'b0;
    step();
    chk("wj.addr", imemaddr, 32'hFFFF_FFFC);
    jump = 1'b0; ihit = 1'b1; imemload = 32'h1234_5678;
    step();
    chk("wrap.addr", imemaddr, 32'h0);
    chk_ifid("wrap", 32'h1234_5678, 32'h0, 1'b1);
    imemload = 32'h8765_4321;
    step();
    chk("w2.addr", imemaddr, 32'h4);
    chk_ifid("w2", 32'h8765_4321, 32'h4, 1'b1);

    // halt while stalled
    halt = 1'b1; stall_ifid = 1'b1; pc_en = 1'b0; ihit = 1'b0;
    step();
    chk("halt.halted", {31'd0, halted}, 32'd1);
    chk("halt.ren", {31'd0, imemREN}, 32'd0);
    chk("halt.addr", imemaddr, 32'h4);
    chk_ifid("halt", 32'h0, 32'h0, 1'b0);
    halt = 1'b0; stall_ifid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pc_en = k[0]; ihit = ~k[0]; jump = k[1]; jump_target = 32'h80;
      step();
      chk("hold.addr", imemaddr, 32'h4);
      chk("hold.halted", {31'd0, halted}, 32'd1);
      chk("hold.ren", {31'd0, imemREN}, 32'd0);
    end

    // asynchronous reset clears halt
    jump = 1'b0; nRST = 1'b0;
    #1;
    chk("hrst.addr", imemaddr, 32'h0);
    chk("hrst.halted", {31'd0, halted}, 32'd0);

    // reset mid-fetch drops the read request immediately
    pc_en = 1'b1; ihit = 1'b1;
    step();
    nRST = 1'b1;
    step();
    chk("mf.ren", {31'd0, imemREN}, 32'd1);
    step();
    chk("mf.addr", imemaddr, 32'h4);
    #2 nRST = 1'b0;
    #1;
    chk("mfrst.ren", {31'd0, imemREN}, 32'd0);
    chk("mfrst.addr", imemaddr, 32'h0);
    chk("mfrst.valid", {31'd0, valid_ifid}, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
